// File: rtl/mem_io_responder.sv
// mem_io_responder
//
// Memory-side responder for a CPU's byte-wide memory bus. It holds the
// program/data RAM and decodes an I/O window at addresses 0x30000 and up.
//
// The I/O window provides:
//   - a host byte input FIFO (rx)
//   - a byte output FIFO (tx)
//   - a cycle counter with a snapshot register
//   - a sticky program-stop flag
//
// It also drives the CPU run enable. The CPU is paused when output buffering
// is nearly full, and it stays paused after a program stop until reset.
//
// Ports
//   clk_in, rst_in      clock; synchronous active-high reset
//   cpu_mem_a_i         CPU byte address (only [17:0] decoded)
//   cpu_mem_wr_i        1 = write, 0 = read
//   cpu_mem_dout_i      write data from the CPU
//   cpu_mem_din_o       registered read data (1-cycle latency)
//   cpu_rdy_o           CPU run enable; every bus access requires it high
//   in_valid_i/in_data_i/in_ready_o      host -> rx FIFO
//   out_valid_o/out_data_o/out_ready_i   tx FIFO -> sink
//   prog_stop_o         sticky stop flag
//   cycle_cnt_o         free-running cycle counter, frozen after stop
//
// Handshake rule (both byte streams): a byte moves on a rising clk_in edge
// exactly when valid and ready are both high in the cycle before that edge.
// valid never depends on ready.
//
// I/O map (read / write)
//   0x30000  pop rx head, 0x00 if empty  /  push nonzero byte to tx
//   0x30004  counter[7:0] + snapshot     /  push 0x00 to tx, set stop
//   0x30005..0x30007  snapshot bytes 1..3 / ignored
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_mem_a_i,
    input  logic        cpu_mem_wr_i,
    input  logic [7:0]  cpu_mem_dout_i,
    output logic [7:0]  cpu_mem_din_o,
    output logic        cpu_rdy_o,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    input  logic        out_ready_i,
    output logic        prog_stop_o,
    output logic [31:0] cycle_cnt_o
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    // One entry is kept spare. A write can be sampled in the same cycle that
    // rdy drops, and that write still needs somewhere to land.
    localparam logic [CW-1:0] CNT_RDY_MAX = CW'(DEPTH - 2);

    // Storage
    logic [7:0] r_ram    [0:(1 << RAM_ADDR_WIDTH)-1];
    logic [7:0] r_tx_mem [0:DEPTH-1];
    logic [7:0] r_rx_mem [0:DEPTH-1];

    // Registers
    logic [PW-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic [PW-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic [CW-1:0] r_tx_count, r_rx_count;
    logic [7:0]    r_din;
    logic [31:0]   r_cnt;
    logic [31:0]   r_snap;
    logic          r_stop;

    // Decode
    logic                      w_acc_en;
    logic                      w_rd;
    logic                      w_wr;
    logic                      w_io;
    logic [15:0]               w_off;
    logic                      w_off_data;
    logic                      w_off_cnt;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
    logic                      w_ram_we;
    logic                      w_tx_push;
    logic                      w_tx_pop;
    logic [7:0]                w_tx_wdata;
    logic                      w_rx_push;
    logic                      w_rx_pop;
    logic                      w_rx_empty;
    logic                      w_snap_en;
    logic                      w_stop_set;
    logic [7:0]                w_rd_data;
    logic                      w_unused_addr;

    assign w_unused_addr = ^cpu_mem_a_i[31:18];

    assign w_acc_en   = cpu_rdy_o;
    assign w_rd       = w_acc_en && !cpu_mem_wr_i;
    assign w_wr       = w_acc_en && cpu_mem_wr_i;
    assign w_io       = (cpu_mem_a_i[17:16] == 2'b11);
    assign w_off      = cpu_mem_a_i[15:0];
    assign w_off_data = (w_off == 16'h0000);
    assign w_off_cnt  = (w_off == 16'h0004);
    assign w_ram_addr = cpu_mem_a_i[RAM_ADDR_WIDTH-1:0];
    assign w_ram_we   = w_wr && !w_io;

    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_push  = in_valid_i && in_ready_o;
    // An empty rx read returns 0x00 and does not move the pointers.
    // A host push arriving in the same cycle therefore still lands.
    assign w_rx_pop   = w_rd && w_io && w_off_data && !w_rx_empty;

    assign w_tx_push  = w_wr && w_io &&
                        ((w_off_data && (cpu_mem_dout_i != 8'h00)) || w_off_cnt);
    assign w_tx_wdata = w_off_cnt ? 8'h00 : cpu_mem_dout_i;
    assign w_tx_pop   = out_valid_o && out_ready_i;

    assign w_snap_en  = w_rd && w_io && w_off_cnt;
    assign w_stop_set = w_wr && w_io && w_off_cnt;

    // Outputs
    assign cpu_rdy_o     = !r_stop && (r_tx_count <= CNT_RDY_MAX);
    assign in_ready_o    = (r_rx_count != CNT_FULL);
    assign out_valid_o   = (r_tx_count != '0);
    assign out_data_o    = r_tx_mem[r_tx_rd_ptr];
    assign cpu_mem_din_o = r_din;
    assign prog_stop_o   = r_stop;
    assign cycle_cnt_o   = r_cnt;

    // Read data selection; registered into r_din below.
    always_comb begin
        w_rd_data = 8'h00;
        if (!w_io) begin
            w_rd_data = r_ram[w_ram_addr];
        end else begin
            case (w_off)
                16'h0000: w_rd_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];
                16'h0004: w_rd_data = r_cnt[7:0];
                16'h0005: w_rd_data = r_snap[15:8];
                16'h0006: w_rd_data = r_snap[23:16];
                16'h0007: w_rd_data = r_snap[31:24];
                default:  w_rd_data = 8'h00;
            endcase
        end
    end

    // RAM and FIFO storage are not reset. Their contents are only
    // observable through the pointers and counts, and those are reset.
    always_ff @(posedge clk_in) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= cpu_mem_dout_i;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= w_tx_wdata;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
            r_din       <= 8'h00;
            r_cnt       <= 32'h0;
            r_snap      <= 32'h0;
            r_stop      <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + CNT_ONE;
                2'b01:   r_tx_count <= r_tx_count - CNT_ONE;
                default: r_tx_count <= r_tx_count;
            endcase

            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase

            // Writes leave the read data register untouched.
            if (w_rd) r_din <= w_rd_data;

            if (w_snap_en)  r_snap <= r_cnt;
            if (w_stop_set) r_stop <= 1'b1;
            if (!r_stop)    r_cnt  <= r_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder.
// Stimulus is applied 1 ns after each rising edge. The DUT outputs are
// checked at that same point, so they reflect the state after that edge.
// The sink monitor samples on the falling edge, where the inputs and
// outputs for the next rising edge are both stable.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] cpu_mem_a_i = 32'h0003_0008;
    logic        cpu_mem_wr_i = 1'b0;
    logic [7:0]  cpu_mem_dout_i = 8'h00;
    logic [7:0]  cpu_mem_din_o;
    logic        cpu_rdy_o;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic        out_ready_i = 1'b0;
    logic        prog_stop_o;
    logic [31:0] cycle_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rcv_q[$];

    mem_io_responder #(.RAM_ADDR_WIDTH(17), .FIFO_DEPTH_LOG2(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cpu_mem_a_i(cpu_mem_a_i), .cpu_mem_wr_i(cpu_mem_wr_i),
        .cpu_mem_dout_i(cpu_mem_dout_i), .cpu_mem_din_o(cpu_mem_din_o),
        .cpu_rdy_o(cpu_rdy_o),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .prog_stop_o(prog_stop_o), .cycle_cnt_o(cycle_cnt_o)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    // Sink monitor and tx overflow assertion
    always @(negedge clk_in) begin
        if (!rst_in && out_valid_o && out_ready_i) rcv_q.push_back(out_data_o);
        if (!rst_in) begin
            n_checks++;
            if (dut.r_tx_count > 5'd15) begin
                n_fail++;
                $display("FAIL tx_overflow: tx count %0d, limit 15", dut.r_tx_count);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_mem_a_i    = a;
        cpu_mem_wr_i   = wr;
        cpu_mem_dout_i = d;
        tick();
    endtask

    task automatic idle();
        cyc(32'h0003_0008, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        idle();
        tick();
        rst_in = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h exp 00", cpu_mem_din_o); end
        n_checks++;
        if (prog_stop_o !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %b exp 0", prog_stop_o); end
        n_checks++;
        if (cycle_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", cycle_cnt_o); end
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid_o); end
        n_checks++;
        if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready_o); end
        n_checks++;
        if (cpu_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b exp 1", cpu_rdy_o); end
    endtask

    task automatic test_ram();
        cyc(32'h0000_0010, 1'b1, 8'hA5);
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL ram_wr_no_resp: got %h exp 00", cpu_mem_din_o); end
        cyc(32'h0000_0010, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'hA5) begin n_fail++; $display("FAIL ram_rd_a5: got %h exp a5", cpu_mem_din_o); end
        cyc(32'h0001_FFFF, 1'b1, 8'h5A);
        n_checks++;
        if (cpu_mem_din_o !== 8'hA5) begin n_fail++; $display("FAIL ram_wr_hold: got %h exp a5", cpu_mem_din_o); end
        cyc(32'h0000_0000, 1'b1, 8'hC3);
        cyc(32'h0001_FFFF, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h5A) begin n_fail++; $display("FAIL ram_rd_top: got %h exp 5a", cpu_mem_din_o); end
        cyc(32'h0000_0000, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'hC3) begin n_fail++; $display("FAIL ram_rd_zero: got %h exp c3", cpu_mem_din_o); end
        idle();
    endtask

    task automatic test_tx_filter();
        rcv_q.delete();
        out_ready_i = 1'b1;
        cyc(32'h0003_0000, 1'b1, 8'h48);
        cyc(32'h0003_0000, 1'b1, 8'h00);
        cyc(32'h0003_0000, 1'b1, 8'h69);
        repeat (4) idle();
        n_checks++;
        if (rcv_q.size() != 2) begin n_fail++; $display("FAIL tx_filter_count: got %0d exp 2", rcv_q.size()); end
        else begin
            n_checks++;
            if (rcv_q[0] !== 8'h48 || rcv_q[1] !== 8'h69) begin
                n_fail++; $display("FAIL tx_filter_data: got %h %h exp 48 69", rcv_q[0], rcv_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        logic got;
        rcv_q.delete();
        out_ready_i = 1'b0;
        idle();
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (cpu_rdy_o !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_high_%0d: got %b exp 1", i, cpu_rdy_o); end
            cyc(32'h0003_0000, 1'b1, 8'h10 + 8'(i));
        end
        n_checks++;
        if (cpu_rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_low: got %b exp 0", cpu_rdy_o); end
        n_checks++;
        if (out_data_o !== 8'h10) begin n_fail++; $display("FAIL bp_head: got %h exp 10", out_data_o); end
        // Writes presented while paused must be ignored.
        cyc(32'h0003_0000, 1'b1, 8'h1F);
        tick();
        n_checks++;
        if (cpu_rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_hold: got %b exp 0", cpu_rdy_o); end
        out_ready_i = 1'b1;
        got = 1'b0;
        k = 0;
        while (k < 10 && !got) begin
            if (cpu_rdy_o) got = 1'b1;
            else k++;
            tick();
        end
        n_checks++;
        if (!got || k != 1) begin n_fail++; $display("FAIL bp_rdy_return: got=%b after %0d cycles exp 1", got, k); end
        repeat (20) idle();
        n_checks++;
        if (rcv_q.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d exp 16", rcv_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (rcv_q[i] !== 8'h10 + 8'(i)) begin
                    n_fail++; $display("FAIL bp_order_%0d: got %h exp %h", i, rcv_q[i], 8'h10 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_rx();
        in_valid_i = 1'b1; in_data_i = 8'h31; idle();
        in_data_i = 8'h32; idle();
        in_valid_i = 1'b0;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h31) begin n_fail++; $display("FAIL rx_rd0: got %h exp 31", cpu_mem_din_o); end
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h32) begin n_fail++; $display("FAIL rx_rd1: got %h exp 32", cpu_mem_din_o); end
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL rx_rd_empty: got %h exp 00", cpu_mem_din_o); end
        // Fill beyond capacity; the 17th byte is dropped.
        for (int i = 0; i < 17; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'h40 + 8'(i); idle();
        end
        in_valid_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b exp 0", in_ready_o); end
        for (int i = 0; i < 16; i++) begin
            cyc(32'h0003_0000, 1'b0, 8'h00);
            n_checks++;
            if (cpu_mem_din_o !== 8'h40 + 8'(i)) begin
                n_fail++; $display("FAIL rx_full_rd_%0d: got %h exp %h", i, cpu_mem_din_o, 8'h40 + 8'(i));
            end
        end
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL rx_drop17: got %h exp 00", cpu_mem_din_o); end
        // Push and pop on an empty FIFO in the same cycle.
        in_valid_i = 1'b1; in_data_i = 8'h77;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        in_valid_i = 1'b0;
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL rx_simul_empty: got %h exp 00", cpu_mem_din_o); end
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h77) begin n_fail++; $display("FAIL rx_simul_landed: got %h exp 77", cpu_mem_din_o); end
    endtask

    task automatic test_counter_snapshot();
        do_reset();
        repeat (1000) idle();
        n_checks++;
        if (cycle_cnt_o !== 32'd1000) begin n_fail++; $display("FAIL cnt_1000: got %0d exp 1000", cycle_cnt_o); end
        cyc(32'h0003_0004, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'hE8) begin n_fail++; $display("FAIL snap_b0: got %h exp e8", cpu_mem_din_o); end
        cyc(32'h0003_0005, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h03) begin n_fail++; $display("FAIL snap_b1: got %h exp 03", cpu_mem_din_o); end
        cyc(32'h0003_0006, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL snap_b2: got %h exp 00", cpu_mem_din_o); end
        cyc(32'h0003_0007, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL snap_b3: got %h exp 00", cpu_mem_din_o); end
        n_checks++;
        if (cycle_cnt_o !== 32'd1004) begin n_fail++; $display("FAIL cnt_advanced: got %0d exp 1004", cycle_cnt_o); end
    endtask

    task automatic test_stop();
        rcv_q.delete();
        out_ready_i = 1'b0;
        do_reset();
        cyc(32'h0000_0020, 1'b1, 8'h11);
        cyc(32'h0003_0000, 1'b1, 8'h41);
        cyc(32'h0003_0000, 1'b1, 8'h42);
        cyc(32'h0003_0004, 1'b1, 8'h55);
        n_checks++;
        if (prog_stop_o !== 1'b1) begin n_fail++; $display("FAIL stop_flag: got %b exp 1", prog_stop_o); end
        n_checks++;
        if (cpu_rdy_o !== 1'b0) begin n_fail++; $display("FAIL stop_rdy: got %b exp 0", cpu_rdy_o); end
        cyc(32'h0000_0020, 1'b1, 8'h22);
        out_ready_i = 1'b1;
        repeat (5) idle();
        n_checks++;
        if (rcv_q.size() != 3) begin n_fail++; $display("FAIL stop_sink_count: got %0d exp 3", rcv_q.size()); end
        else begin
            n_checks++;
            if (rcv_q[0] !== 8'h41 || rcv_q[1] !== 8'h42 || rcv_q[2] !== 8'h00) begin
                n_fail++; $display("FAIL stop_sink_data: got %h %h %h exp 41 42 00", rcv_q[0], rcv_q[1], rcv_q[2]);
            end
        end
        n_checks++;
        if (cycle_cnt_o !== 32'd4) begin n_fail++; $display("FAIL stop_cnt_frozen: got %0d exp 4", cycle_cnt_o); end
        n_checks++;
        if (cpu_rdy_o !== 1'b0 || prog_stop_o !== 1'b1) begin
            n_fail++; $display("FAIL stop_sticky: rdy %b stop %b exp 0 1", cpu_rdy_o, prog_stop_o);
        end
        out_ready_i = 1'b0;
        do_reset();
        cyc(32'h0000_0020, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h11) begin n_fail++; $display("FAIL stop_ram_write_ignored: got %h exp 11", cpu_mem_din_o); end
    endtask

    task automatic test_reset_mid_drain();
        rcv_q.delete();
        out_ready_i = 1'b0;
        do_reset();
        cyc(32'h0000_0020, 1'b0, 8'h00);
        in_valid_i = 1'b1; in_data_i = 8'h99;
        cyc(32'h0003_0000, 1'b1, 8'h43);
        in_valid_i = 1'b0;
        cyc(32'h0003_0000, 1'b1, 8'h44);
        cyc(32'h0003_0004, 1'b1, 8'h01);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        rst_in = 1'b1;
        cyc(32'h0000_0020, 1'b0, 8'h00);
        rst_in = 1'b0;
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL rmd_din: got %h exp 00", cpu_mem_din_o); end
        n_checks++;
        if (prog_stop_o !== 1'b0) begin n_fail++; $display("FAIL rmd_stop: got %b exp 0", prog_stop_o); end
        n_checks++;
        if (cycle_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rmd_cnt: got %0d exp 0", cycle_cnt_o); end
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmd_out_valid: got %b exp 0", out_valid_o); end
        n_checks++;
        if (in_ready_o !== 1'b1 || cpu_rdy_o !== 1'b1) begin
            n_fail++; $display("FAIL rmd_ready: in_ready %b rdy %b exp 1 1", in_ready_o, cpu_rdy_o);
        end
        out_ready_i = 1'b1;
        repeat (4) idle();
        out_ready_i = 1'b0;
        n_checks++;
        if (rcv_q.size() != 1 || rcv_q[0] !== 8'h43) begin
            n_fail++; $display("FAIL rmd_sink: got %0d bytes exp 1 byte 43", rcv_q.size());
        end
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_checks++;
        if (cpu_mem_din_o !== 8'h00) begin n_fail++; $display("FAIL rmd_rx_lost: got %h exp 00", cpu_mem_din_o); end
    endtask

    initial begin
        @(posedge clk_in);
        #1;
        test_reset();
        test_ram();
        test_tx_filter();
        test_backpressure();
        test_rx();
        test_counter_snapshot();
        test_stop();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus: address, write strobe and write data in; read data out.
- Contains the 128KB program/data RAM and decodes the I/O window at 0x30000 and up.
- I/O functions: host byte input (rx FIFO), byte output (tx FIFO), cycle counter, program-stop indication.
- Drives the CPU's ready input so the CPU freezes when output buffering is nearly full or after program stop.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM byte-address width (2^17 bytes = 128KB).
- FIFO_DEPTH_LOG2, 4, log2 of rx and tx FIFO depth (16 entries each).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-high.
- cpu_mem_a_i  input  32  CPU address; only [17:0] decoded.
- cpu_mem_wr_i  input  1  1 = write, 0 = read.
- cpu_mem_dout_i  input  8  write data from CPU.
- cpu_mem_din_o  output  8  read data to CPU, registered.
- cpu_rdy_o  output  1  CPU run enable; low pauses the CPU.
- in_valid_i  input  1  host input byte valid.
- in_data_i  input  8  host input byte.
- in_ready_o  output  1  rx FIFO not full.
- out_valid_o  output  1  tx FIFO not empty.
- out_data_o  output  8  tx FIFO head byte.
- out_ready_i  input  1  sink accepts out_data_o this cycle.
- prog_stop_o  output  1  sticky: program requested stop.
- cycle_cnt_o  output  32  free-running cycle counter (debug).

Behaviour:
- Clock and reset: one clock (clk_in); reset is synchronous and active-high (rst_in).
- Reset values:
  - cpu_mem_din_o = 0, prog_stop_o = 0, cycle_cnt_o = 0.
  - Both FIFOs emptied: out_valid_o = 0, in_ready_o = 1.
  - Snapshot register = 0. RAM contents are not cleared.
- Access enable: acc_en = cpu_rdy_o. When acc_en = 0, the bus is ignored entirely: no RAM write, no FIFO push/pop, no snapshot. cpu_mem_din_o holds its value.
- Decode: io = (cpu_mem_a_i[17:16] == 2'b11). If not io, RAM address = cpu_mem_a_i[RAM_ADDR_WIDTH-1:0].
- RAM read: address sampled at edge N; byte valid on cpu_mem_din_o from edge N+1 through the next edge (1-cycle latency; the CPU consumes it the following cycle).
- RAM write: written at the same edge the request is sampled; no response. cpu_mem_din_o is unchanged.
- I/O reads (also 1-cycle latency):
  - 0x30000: pops the rx head and returns it. If rx is empty, returns 0x00 with no pop.
  - 0x30004: returns the live counter [7:0] and latches the whole counter into the snapshot.
  - 0x30005..0x30007: return snapshot bytes 1..3 (bits [15:8], [23:16], [31:24]).
  - Any other I/O offset: returns 0x00.
- I/O writes:
  - 0x30000 with nonzero data: pushes the byte to tx.
  - 0x30000 with data 0x00: ignored.
  - 0x30004 with any data: pushes 0x00 to tx and sets prog_stop_o.
  - Other I/O offsets: ignored.
- cycle_cnt_o:
  - Increments by 1 every cycle while prog_stop_o = 0; frozen once stopped.
  - Wraps 0xFFFFFFFF -> 0.
- cpu_rdy_o (combinational) = !prog_stop_o && (tx_count <= 2^FIFO_DEPTH_LOG2 - 2). The one spare entry absorbs a write sampled in the same cycle rdy drops. A tx overflow push must never occur; assert this in the bench.
- tx FIFO:
  - A pop occurs when out_valid_o && out_ready_i.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pop from the full state frees space; cpu_rdy_o may rise on the next cycle.
- rx FIFO:
  - Push when in_valid_i && in_ready_o. A push while full is dropped (in_ready_o = 0).
  - Simultaneous host push and CPU pop: the pop returns the old head; if empty, it returns 0x00 and the push still lands.
- Pointers: wrap modulo depth; separate count registers give full/empty.
- After stop: the tx FIFO keeps draining to the sink. The CPU stays paused until reset.
- Reset mid-operation: a pending read response is discarded (cpu_mem_din_o = 0); queued FIFO bytes are lost.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> cpu_mem_din_o = 0xA5 exactly one cycle after the read is sampled; RAM address 0x1FFFF is independent of 0x00000.
- Write 'H', 0x00, 'i' to 0x30000 with out_ready_i = 1 -> sink sees 0x48 then 0x69 only; the 0x00 is dropped.
- Hold out_ready_i = 0 and write 16 bytes -> cpu_rdy_o falls when tx_count reaches 15; the write sampled that cycle is stored (count 15, no overflow); raise out_ready_i -> cpu_rdy_o returns, all bytes arrive in order.
- Host pushes 0x31, 0x32; CPU reads 0x30000 three times -> 0x31, 0x32, 0x00.
- Run 1000 cycles after reset, read 0x30004..0x30007 -> assembled 32-bit value equals the counter at the 0x30004 sample (snapshot consistent even though the counter advanced).
- Write 0x30004 -> prog_stop_o = 1, sink receives 0x00, cycle_cnt_o frozen, cpu_rdy_o stays 0; assert rst_in mid-drain -> all outputs return to reset values the next cycle.
